// File: rtl/tx_frame_sequencer.sv
// Serial TX framer: 0x7E start/end flags around buffer bytes with zero insertion,
// plus a 7-bit abort pattern. Reads bytes from an external buffer via a one-cycle strobe.
//   state        | meaning
//   S_IDLE       | line idles high, waits for a frame request
//   S_START_FLAG | sending opening 0x7E flag, first buffer read issued
//   S_DATA       | shifting bytes LSB-first, 0 inserted after five 1s
//   S_END_FLAG   | sending closing 0x7E flag
//   S_ABORT      | sending 0 followed by six 1s, frame discarded
module tx_frame_sequencer #(
    parameter int MAX_BYTES = 128
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_enable,
    input  logic [7:0] i_tx_frame_len,
    input  logic       i_tx_abort_frame,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_rd_buff,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_aborted_trans
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_FLAG,
        S_DATA,
        S_END_FLAG,
        S_ABORT
    } state_t;

    localparam logic [7:0] LP_FLAG    = 8'h7E;
    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_BYTES);

    state_t     r_state, w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic [2:0] r_ones, w_ones;
    logic [7:0] r_bytes_left, w_bytes_left;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_hold;
    logic       r_rd_d1;
    logic       r_tx, w_tx;
    logic       r_rd, w_rd;
    logic       r_busy;
    logic       r_done, w_done;
    logic       r_aborted, w_aborted;
    logic [2:0] w_cnt_inc;
    logic       w_data_bit;

    assign w_cnt_inc = r_bit_cnt + 3'd1;

    always_comb begin
        w_state      = r_state;
        w_bit_cnt    = r_bit_cnt;
        w_ones       = r_ones;
        w_bytes_left = r_bytes_left;
        w_shift      = r_shift;
        w_tx         = 1'b1;
        w_rd         = 1'b0;
        w_done       = 1'b0;
        w_aborted    = r_aborted;
        w_data_bit   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_tx_enable && (i_tx_frame_len != 8'd0)) begin
                    w_state      = S_START_FLAG;
                    w_bit_cnt    = 3'd0;
                    w_tx         = LP_FLAG[0];
                    w_rd         = 1'b1;
                    w_bytes_left = (i_tx_frame_len > LP_MAX_LEN) ? LP_MAX_LEN : i_tx_frame_len;
                    w_aborted    = 1'b0;
                    w_ones       = 3'd0;
                end
            end

            S_START_FLAG: begin
                if (r_bit_cnt != 3'd7) begin
                    w_bit_cnt = w_cnt_inc;
                    w_tx      = LP_FLAG[w_cnt_inc];
                end else begin
                    w_state      = S_DATA;
                    w_shift      = r_hold;
                    w_bit_cnt    = 3'd0;
                    w_bytes_left = r_bytes_left - 8'd1;
                    w_rd         = (r_bytes_left > 8'd1);
                    w_data_bit   = r_hold[0];
                    w_tx         = w_data_bit;
                    w_ones       = w_data_bit ? 3'd1 : 3'd0;
                end
            end

            S_DATA: begin
                // ones counter already covers the bit on the line, so five means stuff now
                if (r_ones == 3'd5) begin
                    w_tx   = 1'b0;
                    w_ones = 3'd0;
                end else if (r_bit_cnt != 3'd7) begin
                    w_bit_cnt  = w_cnt_inc;
                    w_data_bit = r_shift[w_cnt_inc];
                    w_tx       = w_data_bit;
                    w_ones     = w_data_bit ? (r_ones + 3'd1) : 3'd0;
                end else if (r_bytes_left != 8'd0) begin
                    w_shift      = r_hold;
                    w_bit_cnt    = 3'd0;
                    w_bytes_left = r_bytes_left - 8'd1;
                    w_rd         = (r_bytes_left > 8'd1);
                    w_data_bit   = r_hold[0];
                    w_tx         = w_data_bit;
                    w_ones       = w_data_bit ? (r_ones + 3'd1) : 3'd0;
                end else begin
                    w_state   = S_END_FLAG;
                    w_bit_cnt = 3'd0;
                    w_tx      = LP_FLAG[0];
                end
            end

            S_END_FLAG: begin
                if (r_bit_cnt != 3'd7) begin
                    w_bit_cnt = w_cnt_inc;
                    w_tx      = LP_FLAG[w_cnt_inc];
                end else begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end
            end

            S_ABORT: begin
                if (r_bit_cnt != 3'd6) begin
                    w_bit_cnt = w_cnt_inc;
                end else begin
                    w_state   = S_IDLE;
                    w_aborted = 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        // abort outranks every in-frame transition, including the final end-flag bit
        if (i_tx_abort_frame &&
            ((r_state == S_START_FLAG) || (r_state == S_DATA) || (r_state == S_END_FLAG))) begin
            w_state   = S_ABORT;
            w_bit_cnt = 3'd0;
            w_tx      = 1'b0;
            w_ones    = 3'd0;
            w_rd      = 1'b0;
            w_done    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_ones       <= 3'd0;
            r_bytes_left <= 8'd0;
            r_shift      <= 8'd0;
            r_hold       <= 8'd0;
            r_rd_d1      <= 1'b0;
            r_tx         <= 1'b1;
            r_rd         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_bit_cnt    <= w_bit_cnt;
            r_ones       <= w_ones;
            r_bytes_left <= w_bytes_left;
            r_shift      <= w_shift;
            r_rd_d1      <= r_rd;
            if (r_rd_d1) begin
                r_hold <= i_tx_data;
            end
            r_tx         <= w_tx;
            r_rd         <= w_rd;
            r_busy       <= (w_state != S_IDLE);
            r_done       <= w_done;
            r_aborted    <= w_aborted;
        end
    end

    assign o_tx_rd_buff       = r_rd;
    assign o_tx               = r_tx;
    assign o_tx_busy          = r_busy;
    assign o_tx_done          = r_done;
    assign o_tx_aborted_trans = r_aborted;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: directed and random frames compared bit-by-bit
// against a flag/stuffing model built from byte lists.
module tb_tx_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic [7:0] tx_frame_len;
    logic       tx_abort_frame;
    logic [7:0] tx_data;
    logic       tx_rd_buff;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_aborted_trans;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_bytes[$];
    bit         q_exp[$];
    logic [7:0] flag_v = 8'h7E;

    always #5 clk = ~clk;

    tx_frame_sequencer #(.MAX_BYTES(128)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_tx_enable        (tx_enable),
        .i_tx_frame_len     (tx_frame_len),
        .i_tx_abort_frame   (tx_abort_frame),
        .i_tx_data          (tx_data),
        .o_tx_rd_buff       (tx_rd_buff),
        .o_tx               (tx),
        .o_tx_busy          (tx_busy),
        .o_tx_done          (tx_done),
        .o_tx_aborted_trans (tx_aborted_trans)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // line image of a whole frame: flag, stuffed data, flag
    function automatic void build_expected(input int nbytes);
        int ones;
        bit d;
        ones = 0;
        q_exp.delete();
        for (int b = 0; b < 8; b++) q_exp.push_back(flag_v[b]);
        for (int k = 0; k < nbytes; k++) begin
            for (int b = 0; b < 8; b++) begin
                d = q_bytes[k][b];
                q_exp.push_back(d);
                ones = d ? ones + 1 : 0;
                if (ones == 5) begin
                    q_exp.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        for (int b = 0; b < 8; b++) q_exp.push_back(flag_v[b]);
    endfunction

    // abort_at_in: -1 none, -2 on last end-flag bit, -3 random position, else line index
    task automatic run_frame(input int len, input int abort_at_in, input bit abort_with_start,
                             output int reads);
        int eff, abort_at, ridx, late_rd, n;
        bit pend;
        eff = (len > 128) ? 128 : len;
        while (q_bytes.size() < eff) q_bytes.push_back(8'($urandom));
        build_expected(eff);
        abort_at = abort_at_in;
        if (abort_at == -2) abort_at = q_exp.size() - 1;
        else if (abort_at == -3) abort_at = $urandom_range(0, q_exp.size() - 1);
        if (abort_at >= 0) begin
            while (q_exp.size() > abort_at + 1) void'(q_exp.pop_back());
            q_exp.push_back(1'b0);
            repeat (6) q_exp.push_back(1'b1);
        end
        reads = 0; ridx = 0; late_rd = 0; pend = 1'b0;
        n = q_exp.size();

        @(negedge clk);
        tx_enable      = 1'b1;
        tx_frame_len   = 8'(len);
        tx_abort_frame = abort_with_start;

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("tx[%0d]", i), int'(tx), int'(q_exp[i]));
            chk($sformatf("busy[%0d]", i), int'(tx_busy), 1);
            if (pend) begin
                tx_data = (ridx < q_bytes.size()) ? q_bytes[ridx] : 8'h00;
                ridx++;
                pend = 1'b0;
            end
            if (tx_rd_buff) begin
                reads++;
                pend = 1'b1;
                if (abort_at >= 0 && i > abort_at) late_rd++;
            end
            tx_enable    = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tx_frame_len = 8'($urandom);
            if (abort_at < 0 || i < abort_at) tx_abort_frame = 1'b0;
            else if (i == abort_at)           tx_abort_frame = 1'b1;
            else                              tx_abort_frame = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        chk("idle_tx", int'(tx), 1);
        chk("idle_busy", int'(tx_busy), 0);
        chk("done_pulse", int'(tx_done), (abort_at < 0) ? 1 : 0);
        chk("aborted", int'(tx_aborted_trans), (abort_at >= 0) ? 1 : 0);
        tx_enable      = 1'b0;
        tx_abort_frame = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle2_tx", int'(tx), 1);
        chk("idle2_busy", int'(tx_busy), 0);
        chk("done_once", int'(tx_done), 0);
        chk("aborted_hold", int'(tx_aborted_trans), (abort_at >= 0) ? 1 : 0);
        tx_abort_frame = 1'b0;
        if (abort_at < 0) chk("reads", reads, eff);
        else begin
            chk("reads_bound", int'(reads <= eff), 1);
            chk("rd_in_abort", late_rd, 0);
        end
        q_bytes.delete();
    endtask

    initial begin
        int reads, rd_seen, len;
        rst = 1'b1; tx_enable = 1'b0; tx_frame_len = 8'd0;
        tx_abort_frame = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_rd", int'(tx_rd_buff), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_aborted", int'(tx_aborted_trans), 0);
        rst = 1'b0;

        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle20_tx", int'(tx), 1);
            chk("idle20_busy", int'(tx_busy), 0);
            if (tx_rd_buff) rd_seen++;
        end
        chk("idle20_rd", rd_seen, 0);

        q_bytes.push_back(8'h00);
        run_frame(1, -1, 1'b0, reads);
        q_bytes.push_back(8'hFF);
        run_frame(1, -1, 1'b0, reads);
        q_bytes.push_back(8'hF0); q_bytes.push_back(8'h03);
        run_frame(2, -1, 1'b0, reads);

        // abort while the second byte (no stuffing in byte one) is on the line
        q_bytes.push_back(8'h55); q_bytes.push_back(8'hAA);
        q_bytes.push_back(8'h12); q_bytes.push_back(8'h34);
        run_frame(4, 19, 1'b0, reads);
        chk("abort_reads_2or3", int'(reads >= 2 && reads <= 3), 1);

        @(negedge clk);
        tx_enable = 1'b1; tx_frame_len = 8'd0;
        rd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len0_busy", int'(tx_busy), 0);
            chk("len0_tx", int'(tx), 1);
            if (tx_rd_buff) rd_seen++;
        end
        tx_enable = 1'b0;
        chk("len0_rd", rd_seen, 0);

        run_frame(3, -1, 1'b1, reads);
        run_frame(2, -2, 1'b0, reads);
        run_frame(3, 3, 1'b0, reads);
        run_frame(200, -1, 1'b0, reads);

        @(negedge clk);
        tx_enable = 1'b1; tx_frame_len = 8'd3; tx_data = 8'hC3;
        @(negedge clk);
        tx_enable = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_busy", int'(tx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(tx_busy), 0);
        chk("midrst_done", int'(tx_done), 0);
        chk("midrst_aborted", int'(tx_aborted_trans), 0);
        chk("midrst_rd", int'(tx_rd_buff), 0);
        rst = 1'b0;
        run_frame(3, -1, 1'b0, reads);

        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 12);
            run_frame(len, ($urandom_range(0, 3) == 0) ? -3 : -1, 1'($urandom_range(0, 1)), reads);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
